// File: rtl/mcp300x_pkg.sv
// Shared MCP300x definitions: responder state encoding and frame sizes.
// Imported by the responder and by the matching SPI master.
package mcp300x_pkg;

  localparam int MCP300X_DATA_W   = 10;
  localparam int MCP300X_CMD_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CMD,
    ST_SAMPLE,
    ST_NULL,
    ST_DATA,
    ST_DONE
  } state_t;

  // A CS rise in these states cuts a transfer short.
  function automatic logic abortable(input state_t s);
    return s inside {ST_CMD, ST_SAMPLE, ST_NULL, ST_DATA};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizer chain with registered rise/fall detection for one SPI pin.
// Edges are suppressed until the chain holds only real pin samples.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES:0]   vld;
  logic                   prev;

  // vld tracks which flops still hold the reset preset rather than pin data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
      vld   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
      vld   <= {vld[SYNC_STAGES-1:0], 1'b1};
      rise  <= vld[SYNC_STAGES] & chain[SYNC_STAGES-1] & ~prev;
      fall  <= vld[SYNC_STAGES] & ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/mcp300x_responder.sv
// SPI-slave model of an MCP3004/3008 ADC in the system clock domain.
// Decodes start/SGL/D2..D0 and returns a user-supplied 10-bit sample.
module mcp300x_responder
  import mcp300x_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ad_ncs_i,
  input  logic                      ad_clk_i,
  input  logic                      ad_din_i,
  output logic                      ad_dout_o,
  output logic                      ad_dout_oe_o,
  output logic                      req_o,
  output logic                      single_o,
  output logic [2:0]                chn_o,
  input  logic [MCP300X_DATA_W-1:0] data_i,
  output logic                      eoc_o,
  output logic                      abort_o
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_rise, sck_fall, unused_sck_lvl;
  logic din_lvl, unused_din_rise, unused_din_fall;
  logic sck_r, sck_f;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pin   (ad_ncs_i),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pin   (ad_clk_i),
    .level (unused_sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pin   (ad_din_i),
    .level (din_lvl),
    .rise  (unused_din_rise),
    .fall  (unused_din_fall)
  );

  assign sck_r = sck_rise & ~cs_lvl;
  assign sck_f = sck_fall & ~cs_lvl;

  state_t                    state;
  logic [3:0]                cnt;
  logic [2:0]                cmd;
  logic [MCP300X_DATA_W-1:0] sr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cmd          <= '0;
      sr           <= '0;
      ad_dout_o    <= 1'b0;
      ad_dout_oe_o <= 1'b0;
      req_o        <= 1'b0;
      eoc_o        <= 1'b0;
      abort_o      <= 1'b0;
      single_o     <= 1'b0;
      chn_o        <= '0;
    end else begin
      req_o   <= 1'b0;
      eoc_o   <= 1'b0;
      abort_o <= 1'b0;
      if (cs_rise) begin
        state        <= ST_IDLE;
        ad_dout_o    <= 1'b0;
        ad_dout_oe_o <= 1'b0;
        abort_o      <= abortable(state);
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cs_fall) state <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (sck_r && din_lvl) begin
              state <= ST_CMD;
              cnt   <= '0;
            end
          end
          ST_CMD: begin
            if (sck_r) begin
              cmd <= {cmd[1:0], din_lvl};
              cnt <= cnt + 4'd1;
              if (cnt == 4'(MCP300X_CMD_BITS - 1)) begin
                single_o <= cmd[2];
                chn_o    <= {cmd[1:0], din_lvl};
                req_o    <= 1'b1;
                cnt      <= '0;
                state    <= ST_SAMPLE;
              end
            end
          end
          // cnt marks that the sample-clock rising edge has passed.
          ST_SAMPLE: begin
            if (sck_r) begin
              cnt <= 4'd1;
            end else if (sck_f && cnt == 4'd1) begin
              sr           <= data_i;
              ad_dout_o    <= 1'b0;
              ad_dout_oe_o <= 1'b1;
              cnt          <= '0;
              state        <= ST_NULL;
            end
          end
          ST_NULL: begin
            if (sck_f) begin
              ad_dout_o <= sr[MCP300X_DATA_W-1];
              sr        <= {sr[MCP300X_DATA_W-2:0], 1'b0};
              cnt       <= cnt + 4'd1;
              if (cnt == 4'(MCP300X_DATA_W - 1)) state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sck_r) begin
              eoc_o <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (sck_f) ad_dout_o <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp300x_responder.sv
// Directed bench for mcp300x_responder: a simple SPI master drives
// transfers and immediate assertions check decode, data, abort and reset.
module tb_mcp300x_responder;
  import mcp300x_pkg::*;

  localparam int S = 2;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       ncs = 1'b1;
  logic       sck = 1'b0;
  logic       din = 1'b0;
  logic [9:0] data_i = '0;
  logic       dout, oe, req, single, eoc, abort;
  logic [2:0] chn;

  int ncmp = 0;
  int nfail = 0;
  int nreq = 0;
  int neoc = 0;
  int nabort = 0;

  mcp300x_responder #(.SYNC_STAGES(S)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .ad_ncs_i     (ncs),
    .ad_clk_i     (sck),
    .ad_din_i     (din),
    .ad_dout_o    (dout),
    .ad_dout_oe_o (oe),
    .req_o        (req),
    .single_o     (single),
    .chn_o        (chn),
    .data_i       (data_i),
    .eoc_o        (eoc),
    .abort_o      (abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req) nreq++;
    if (eoc) neoc++;
    if (abort) nabort++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_cycle(input logic mosi, output logic miso);
    din = mosi;
    waitc(H);
    sck = 1'b1;
    miso = dout;
    waitc(H);
    sck = 1'b0;
  endtask

  task automatic xfer(input int nlead, input logic sgl,
                      input logic [2:0] ch, input int ndata,
                      input int nextra, output logic nullb,
                      output logic [9:0] rd);
    logic m;
    ncs = 1'b0;
    waitc(H);
    for (int i = 0; i < nlead; i++) bit_cycle(1'b0, m);
    bit_cycle(1'b1, m);
    bit_cycle(sgl, m);
    bit_cycle(ch[2], m);
    bit_cycle(ch[1], m);
    bit_cycle(ch[0], m);
    bit_cycle(1'b0, m);
    bit_cycle(1'b0, nullb);
    rd = '0;
    for (int i = 0; i < ndata; i++) begin
      bit_cycle(1'b0, m);
      rd = {rd[8:0], m};
    end
    for (int i = 0; i < nextra; i++) begin
      bit_cycle(1'b0, m);
      chk("overclock_dout", 32'(m), 32'd0);
    end
    waitc(H);
  endtask

  task automatic end_cs();
    ncs = 1'b1;
    waitc(H + S + 4);
  endtask

  logic       nb;
  logic [9:0] rd;
  int         r0, e0, a0;
  logic [9:0] lb_val [4];

  initial begin
    lb_val[0] = 10'h123;
    lb_val[1] = 10'h2DB;
    lb_val[2] = 10'h0F5;
    lb_val[3] = 10'h3C0;

    waitc(3);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_eoc", 32'(eoc), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_single", 32'(single), 32'd0);
    chk("rst_chn", 32'(chn), 32'd0);
    rst_i = 1'b1;
    waitc(S + 4);

    // normal transfer: single-ended channel 3
    r0 = nreq; e0 = neoc; a0 = nabort;
    data_i = 10'h2A5;
    xfer(0, 1'b1, 3'd3, 10, 0, nb, rd);
    chk("norm_req", 32'(nreq - r0), 32'd1);
    chk("norm_chn", 32'(chn), 32'd3);
    chk("norm_single", 32'(single), 32'd1);
    chk("norm_null", 32'(nb), 32'd0);
    chk("norm_data", 32'(rd), 32'h2A5);
    end_cs();
    chk("norm_eoc", 32'(neoc - e0), 32'd1);
    chk("norm_abort", 32'(nabort - a0), 32'd0);
    chk("norm_oe_idle", 32'(oe), 32'd0);

    // leading zeros, differential channel 6
    r0 = nreq; e0 = neoc;
    data_i = 10'h3FF;
    xfer(3, 1'b0, 3'd6, 10, 0, nb, rd);
    chk("lead_req", 32'(nreq - r0), 32'd1);
    chk("lead_chn", 32'(chn), 32'd6);
    chk("lead_single", 32'(single), 32'd0);
    chk("lead_null", 32'(nb), 32'd0);
    chk("lead_data", 32'(rd), 32'h3FF);
    end_cs();
    chk("lead_eoc", 32'(neoc - e0), 32'd1);

    // abort after 4 data bits
    e0 = neoc; a0 = nabort;
    data_i = 10'h155;
    xfer(0, 1'b1, 3'd1, 4, 0, nb, rd);
    chk("abort_partial", 32'(rd[3:0]), 32'h5);
    chk("abort_oe_pre", 32'(oe), 32'd1);
    ncs = 1'b1;
    waitc(S + 1);
    chk("abort_oe_hold", 32'(oe), 32'd1);
    chk("abort_early", 32'(abort), 32'd0);
    waitc(1);
    chk("abort_oe_low", 32'(oe), 32'd0);
    chk("abort_pulse", 32'(abort), 32'd1);
    waitc(1);
    chk("abort_one_cycle", 32'(abort), 32'd0);
    waitc(H);
    chk("abort_count", 32'(nabort - a0), 32'd1);
    chk("abort_no_eoc", 32'(neoc - e0), 32'd0);

    e0 = neoc;
    data_i = 10'h001;
    xfer(0, 1'b1, 3'd2, 10, 0, nb, rd);
    chk("post_abort_data", 32'(rd), 32'h001);
    end_cs();
    chk("post_abort_eoc", 32'(neoc - e0), 32'd1);

    // over-clocking past B0
    e0 = neoc; a0 = nabort;
    data_i = 10'h0F0;
    xfer(1, 1'b1, 3'd7, 10, 5, nb, rd);
    chk("over_data", 32'(rd), 32'h0F0);
    chk("over_oe", 32'(oe), 32'd1);
    end_cs();
    chk("over_eoc", 32'(neoc - e0), 32'd1);
    chk("over_abort", 32'(nabort - a0), 32'd0);

    // reset in the data phase, CS held low across release
    r0 = nreq; e0 = neoc; a0 = nabort;
    data_i = 10'h2F0;
    xfer(0, 1'b1, 3'd5, 5, 0, nb, rd);
    chk("mid_chn_before", 32'(chn), 32'd5);
    rst_i = 1'b0;
    waitc(1);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_oe", 32'(oe), 32'd0);
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_eoc", 32'(eoc), 32'd0);
    chk("mid_rst_abort", 32'(abort), 32'd0);
    chk("mid_rst_single", 32'(single), 32'd0);
    chk("mid_rst_chn", 32'(chn), 32'd0);
    rst_i = 1'b1;
    waitc(S + 4);
    xfer(0, 1'b1, 3'd4, 10, 0, nb, rd);
    chk("mid_no_req", 32'(nreq - r0), 32'd1);
    chk("mid_no_oe", 32'(oe), 32'd0);
    chk("mid_no_data", 32'(rd), 32'd0);
    end_cs();
    chk("mid_no_abort", 32'(nabort - a0), 32'd0);
    chk("mid_no_eoc", 32'(neoc - e0), 32'd0);
    data_i = 10'h2C3;
    xfer(0, 1'b0, 3'd2, 10, 0, nb, rd);
    chk("mid_fresh_data", 32'(rd), 32'h2C3);
    chk("mid_fresh_chn", 32'(chn), 32'd2);
    end_cs();
    chk("mid_fresh_eoc", 32'(neoc - e0), 32'd1);

    // loopback over four values
    for (int k = 0; k < 4; k++) begin
      e0 = neoc;
      data_i = lb_val[k];
      xfer(k, k[0], 3'(k + 1), 10, 0, nb, rd);
      chk("loop_data", 32'(rd), 32'(lb_val[k]));
      chk("loop_chn", 32'(chn), 32'(k + 1));
      end_cs();
      chk("loop_eoc", 32'(neoc - e0), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
